decode_pipe: RTL and testbench
==============================

// Module: decode_pipe
// PURPOSE
//  Parametrised decode stage of the ARC MIPS pipeline: regfile, instr decoder, imm extension, ID/EX register.
//  Adds load-use interlock, flush and stall; 1-cycle latency, fetch -> execute.
// PARAMETERS
//  XLEN       32  datapath width; must be >= 32
//  HAZARD_EN  1   1 = load-use interlock active; 0 = never stall on load-use
//  BYPASS_EN  1   1 = WB write visible to same-cycle read; 0 = read sees old value
// PORTS
//  i_clk           in   1     clock, rising edge
//  i_rst           in   1     asynchronous, active-high reset
//  i_valid_IF      in   1     i_instr / i_addr_IncrePC valid
//  i_instr         in   32    MIPS instruction from fetch
//  i_addr_IncrePC  in   XLEN  PC+4 of i_instr
//  i_stall_EX      in   1     execute cannot accept; hold ID/EX register
//  i_flush         in   1     branch/jump taken; kill instr in decode
//  i_wb_en         in   1     regfile write enable from writeback
//  i_wb_addr       in   5     write register index
//  i_wb_data       in   XLEN  write data
//  o_stall_IF      out  1     fetch must hold PC/instr this cycle (combinational)
//  o_valid_EX      out  1     ID/EX contents valid
//  o_data_Rs       out  XLEN  rs operand
//  o_data_Rt       out  XLEN  rt operand
//  o_data_SignExt  out  XLEN  extended immediate
//  o_addr_IncrePC  out  XLEN  PC+4 passed through
//  o_rs/o_rt/o_rd  out  5     register indices (o_rd = dest after RegDst select)
//  o_con_WrBack    out  1     write result to regfile
//  o_con_MemRd     out  1     load
//  o_con_MemWr     out  1     store
//  o_con_Branch    out  1     beq
//  o_con_Jump      out  1     j
//  o_con_AluSrc    out  1     1 = immediate is ALU operand B
//  o_con_AluOp     out  4     0 add,1 sub,2 and,3 or,4 slt
//  o_illegal       out  1     unsupported opcode/funct
// BEHAVIOUR
//  Reset: all ID/EX outputs 0, o_valid_EX=0, all 32 registers cleared; async assert, sync release.
//  Regfile: 32 x XLEN, 2 comb read ports, 1 write port on clk edge; r0 always reads 0, writes ignored.
//  Bypass (BYPASS_EN=1): i_wb_en & i_wb_addr==rs/rt & addr!=0 -> read returns i_wb_data.
//  Decode: R-type op 0x00, funct 0x20 add,0x22 sub,0x24 and,0x25 or,0x2A slt.
//  I-type: 0x23 lw, 0x2B sw, 0x04 beq (AluOp sub), 0x08 addi, 0x0C andi, 0x0D ori; J-type: 0x02 j.
//  Anything else: o_illegal=1, all o_con_* = 0.
//  Imm: addi/lw/sw/beq sign-extend imm16 to XLEN; andi/ori zero-extend.
//  o_rd = instr[15:11] for R-type, else instr[20:16].
//  Load-use hazard (HAZARD_EN=1): o_valid_EX & o_con_MemRd & o_rt!=0 & i_valid_IF & o_rt matches rs
//    (any type) or rt (R-type, sw, beq) -> o_stall_IF=1, bubble loaded (o_valid_EX=0 next cycle).
//  o_stall_IF = hazard | i_stall_EX.
//  ID/EX update, priority high->low each edge:
//    1 i_flush     -> o_valid_EX=0, o_con_* = 0 (other fields don't care)
//    2 i_stall_EX  -> hold all outputs
//    3 hazard      -> o_valid_EX=0, o_con_* = 0
//    4 else        -> load decoded instr; o_valid_EX = i_valid_IF
//  Invalid slot (o_valid_EX=0): all o_con_* forced 0, so downstream never writes/accesses memory.
//  Regfile write proceeds regardless of stall/flush.
//  Reset mid-operation discards in-flight instr and regfile contents.
// TESTING
//  1 Reset during valid add -> next sample all outputs 0, o_valid_EX=0; reading r1..r31 returns 0.
//  2 wb r5=0x1234 same cycle as add r3,r5,r5 -> o_data_Rs=o_data_Rt=0x1234 (BYPASS_EN=1);
//    with BYPASS_EN=0 -> both 0.
//  3 lw r2,0(r1) then add r4,r2,r3 -> o_stall_IF=1 exactly 1 cycle, one bubble,
//    add reaches EX one cycle later; same test with HAZARD_EN=0 -> no stall.
//  4 addi imm 0xFFFF -> o_data_SignExt=0xFFFFFFFF, AluSrc=1; ori imm 0xFFFF -> 0x0000FFFF.
//  5 i_flush and i_stall_EX both high -> next cycle o_valid_EX=0, all o_con_*=0.
//  6 wb r0=0xDEADBEEF then add r1,r0,r0 -> rs/rt 0; opcode 0x3F -> o_illegal=1, o_con_WrBack=0.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: MIPS decode stage with register file, instruction decoder,
// immediate extension and the ID/EX pipeline register.
//   i_clk, i_rst        clock and asynchronous active-high reset
//   i_valid_IF, i_instr, i_addr_IncrePC   instruction from fetch
//   i_stall_EX, i_flush                   pipeline control from later stages
//   i_wb_en, i_wb_addr, i_wb_data         register file write port
//   o_stall_IF          combinational hold request to fetch
//   o_valid_EX, o_data_*, o_addr_IncrePC, o_rs/o_rt/o_rd, o_con_*, o_illegal
//                       registered ID/EX contents
module decode_pipe #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid_IF,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_addr_IncrePC,
  input  logic            i_stall_EX,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall_IF,
  output logic            o_valid_EX,
  output logic [XLEN-1:0] o_data_Rs,
  output logic [XLEN-1:0] o_data_Rt,
  output logic [XLEN-1:0] o_data_SignExt,
  output logic [XLEN-1:0] o_addr_IncrePC,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic            o_con_WrBack,
  output logic            o_con_MemRd,
  output logic            o_con_MemWr,
  output logic            o_con_Branch,
  output logic            o_con_Jump,
  output logic            o_con_AluSrc,
  output logic [3:0]      o_con_AluOp,
  output logic            o_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       wr_back;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [15:0]     imm;
  logic            is_rtype;
  logic            uses_rt;
  logic            zero_ext;
  ctrl_t           ctrl_dec;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] imm_ext;
  logic [4:0]      rd_sel;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            hazard;
  logic [XLEN-1:0] regs [32];
  logic            unused_shamt;

  assign opcode       = i_instr[31:26];
  assign rs           = i_instr[25:21];
  assign rt           = i_instr[20:16];
  assign imm          = i_instr[15:0];
  assign funct        = i_instr[5:0];
  assign unused_shamt = ^i_instr[10:6];
  assign is_rtype     = (opcode == OP_RTYPE);

  always_comb begin
    ctrl_dec = '0;
    uses_rt  = is_rtype;
    zero_ext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec.wr_back = 1'b1;
        case (funct)
          6'h20: ctrl_dec.alu_op = 4'd0;
          6'h22: ctrl_dec.alu_op = 4'd1;
          6'h24: ctrl_dec.alu_op = 4'd2;
          6'h25: ctrl_dec.alu_op = 4'd3;
          6'h2A: ctrl_dec.alu_op = 4'd4;
          default: begin
            ctrl_dec.wr_back = 1'b0;
            ctrl_dec.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_dec.wr_back = 1'b1;
        ctrl_dec.mem_rd  = 1'b1;
        ctrl_dec.alu_src = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.mem_wr  = 1'b1;
        ctrl_dec.alu_src = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = 4'd1;
        uses_rt         = 1'b1;
      end
      OP_ADDI: begin
        ctrl_dec.wr_back = 1'b1;
        ctrl_dec.alu_src = 1'b1;
      end
      OP_ANDI: begin
        ctrl_dec.wr_back = 1'b1;
        ctrl_dec.alu_src = 1'b1;
        ctrl_dec.alu_op  = 4'd2;
        zero_ext         = 1'b1;
      end
      OP_ORI: begin
        ctrl_dec.wr_back = 1'b1;
        ctrl_dec.alu_src = 1'b1;
        ctrl_dec.alu_op  = 4'd3;
        zero_ext         = 1'b1;
      end
      OP_J: ctrl_dec.jump = 1'b1;
      default: ctrl_dec.illegal = 1'b1;
    endcase
  end

  assign imm_ext = zero_ext ? {{(XLEN-16){1'b0}}, imm} : {{(XLEN-16){imm[15]}}, imm};
  assign rd_sel  = is_rtype ? i_instr[15:11] : rt;

  // r0 is never written, so reading it always yields zero without a special case.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (BYPASS_EN && i_wb_en && (i_wb_addr != 5'd0)) begin
      if (i_wb_addr == rs) rs_val = i_wb_data;
      if (i_wb_addr == rt) rt_val = i_wb_data;
    end
  end

  // A load in EX whose destination feeds the instruction now in decode.
  assign hazard = HAZARD_EN && o_valid_EX && ctrl_q.mem_rd && (o_rt != 5'd0) && i_valid_IF
                  && ((o_rt == rs) || (uses_rt && (o_rt == rt)));

  assign o_stall_IF = hazard || i_stall_EX;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_EX     <= 1'b0;
      ctrl_q         <= '0;
      o_data_Rs      <= '0;
      o_data_Rt      <= '0;
      o_data_SignExt <= '0;
      o_addr_IncrePC <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_rd           <= '0;
    end else if (i_flush || (!i_stall_EX && hazard)) begin
      o_valid_EX <= 1'b0;
      ctrl_q     <= '0;
    end else if (!i_stall_EX) begin
      o_valid_EX     <= i_valid_IF;
      // An empty slot carries no control so nothing downstream can act on it.
      ctrl_q         <= i_valid_IF ? ctrl_dec : '0;
      o_data_Rs      <= rs_val;
      o_data_Rt      <= rt_val;
      o_data_SignExt <= imm_ext;
      o_addr_IncrePC <= i_addr_IncrePC;
      o_rs           <= rs;
      o_rt           <= rt;
      o_rd           <= rd_sel;
    end
  end

  assign o_con_WrBack = ctrl_q.wr_back;
  assign o_con_MemRd  = ctrl_q.mem_rd;
  assign o_con_MemWr  = ctrl_q.mem_wr;
  assign o_con_Branch = ctrl_q.branch;
  assign o_con_Jump   = ctrl_q.jump;
  assign o_con_AluSrc = ctrl_q.alu_src;
  assign o_con_AluOp  = ctrl_q.alu_op;
  assign o_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: dut_a uses default parameters, dut_b has
// bypass and load-use interlock disabled; both share all inputs.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_if;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        stall_ex;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        a_stall, a_valid, a_wb, a_mrd, a_mwr, a_br, a_j, a_src, a_ill;
  logic [31:0] a_rsd, a_rtd, a_imm, a_pc;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [3:0]  a_op;
  logic        b_stall, b_valid, b_wb, b_mrd, b_mwr, b_br, b_j, b_src, b_ill;
  logic [31:0] b_rsd, b_rtd, b_imm, b_pc;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [3:0]  b_op;

  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .HAZARD_EN(1'b1), .BYPASS_EN(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid_IF(valid_if), .i_instr(instr),
    .i_addr_IncrePC(pc4), .i_stall_EX(stall_ex), .i_flush(flush),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_stall_IF(a_stall), .o_valid_EX(a_valid), .o_data_Rs(a_rsd), .o_data_Rt(a_rtd),
    .o_data_SignExt(a_imm), .o_addr_IncrePC(a_pc), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd),
    .o_con_WrBack(a_wb), .o_con_MemRd(a_mrd), .o_con_MemWr(a_mwr), .o_con_Branch(a_br),
    .o_con_Jump(a_j), .o_con_AluSrc(a_src), .o_con_AluOp(a_op), .o_illegal(a_ill)
  );

  decode_pipe #(.XLEN(32), .HAZARD_EN(1'b0), .BYPASS_EN(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid_IF(valid_if), .i_instr(instr),
    .i_addr_IncrePC(pc4), .i_stall_EX(stall_ex), .i_flush(flush),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_stall_IF(b_stall), .o_valid_EX(b_valid), .o_data_Rs(b_rsd), .o_data_Rt(b_rtd),
    .o_data_SignExt(b_imm), .o_addr_IncrePC(b_pc), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd),
    .o_con_WrBack(b_wb), .o_con_MemRd(b_mrd), .o_con_MemWr(b_mwr), .o_con_Branch(b_br),
    .o_con_Jump(b_j), .o_con_AluSrc(b_src), .o_con_AluOp(b_op), .o_illegal(b_ill)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [9:0] a_con();
    return {a_wb, a_mrd, a_mwr, a_br, a_j, a_src, a_op};
  endfunction

  initial begin
    rst = 1'b1; valid_if = 1'b0; instr = '0; pc4 = '0; stall_ex = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_stall", a_stall, 1'b0);

    // 1: populate registers, put a valid add in flight, then reset mid-cycle
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055; tick;
    wb_addr = 5'd31; wb_data = 32'h1F1F_1F1F; tick;
    wb_en = 1'b0;
    valid_if = 1'b1; instr = r_type(5'd5, 5'd31, 5'd3, 6'h20); pc4 = 32'h40;
    tick;
    chk("pre_rst_rs", a_rsd, 32'h55);
    chk("pre_rst_rt", a_rtd, 32'h1F1F_1F1F);
    rst = 1'b1; #1;
    chk("arst_valid", a_valid, 1'b0);
    chk("arst_con", a_con(), 10'd0);
    chk("arst_data", {a_rsd, a_rtd}, 64'd0);
    chk("arst_fields", {a_rd, a_pc, a_imm, a_ill}, '0);
    tick;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      instr = r_type(i[4:0], i[4:0], 5'd1, 6'h20);
      tick;
      chk($sformatf("rf_clr_r%0d", i), {a_rsd, a_rtd}, 64'd0);
    end

    // 2: same-cycle write-back bypass
    instr = r_type(5'd5, 5'd5, 5'd3, 6'h20); pc4 = 32'h104;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick;
    wb_en = 1'b0;
    chk("byp_rs", a_rsd, 32'h1234);
    chk("byp_rt", a_rtd, 32'h1234);
    chk("nobyp_rs_rt", {b_rsd, b_rtd}, 64'd0);
    chk("add_rd", a_rd, 5'd3);
    chk("add_idx", {a_rs, a_rt}, {5'd5, 5'd5});
    chk("add_con", a_con(), {1'b1, 5'b00000, 4'd0});
    chk("add_pc", a_pc, 32'h104);
    tick;
    chk("rf_after_wb", b_rsd, 32'h1234);

    // 3: load-use interlock
    instr = i_type(6'h23, 5'd1, 5'd2, 16'h0000);
    tick;
    chk("lw_con", a_con(), {1'b1, 1'b1, 3'b000, 1'b1, 4'd0});
    instr = r_type(5'd2, 5'd3, 5'd4, 6'h20); #1;
    chk("lu_stall_a", a_stall, 1'b1);
    chk("lu_stall_b", b_stall, 1'b0);
    tick;
    chk("lu_bubble_valid", a_valid, 1'b0);
    chk("lu_bubble_con", a_con(), 10'd0);
    chk("lu_b_loaded", {b_valid, b_rd}, {1'b1, 5'd4});
    chk("lu_stall_once", a_stall, 1'b0);
    tick;
    chk("lu_add_ex", {a_valid, a_rd, a_wb}, {1'b1, 5'd4, 1'b1});
    // rt-only dependence through sw after a load
    instr = i_type(6'h23, 5'd1, 5'd7, 16'h0004); tick;
    instr = i_type(6'h2B, 5'd1, 5'd7, 16'h0008); #1;
    chk("lu_sw_rt", a_stall, 1'b1);
    instr = i_type(6'h08, 5'd1, 5'd7, 16'h0001); #1;
    chk("lu_addi_rt_nostall", a_stall, 1'b0);

    // 4: immediate extension and I/J-type controls
    instr = i_type(6'h08, 5'd0, 5'd1, 16'hFFFF); tick;
    chk("addi_imm", a_imm, 32'hFFFF_FFFF);
    chk("addi_con", a_con(), {1'b1, 4'b0000, 1'b1, 4'd0});
    chk("addi_rd", a_rd, 5'd1);
    instr = i_type(6'h0D, 5'd0, 5'd1, 16'hFFFF); tick;
    chk("ori_imm", a_imm, 32'h0000_FFFF);
    chk("ori_op", {a_src, a_op}, {1'b1, 4'd3});
    instr = i_type(6'h0C, 5'd0, 5'd1, 16'h8001); tick;
    chk("andi_imm", {a_imm, a_op}, {32'h0000_8001, 4'd2});
    instr = i_type(6'h2B, 5'd1, 5'd5, 16'h8000); tick;
    chk("sw", {a_imm, a_con()}, {32'hFFFF_8000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd0});
    instr = i_type(6'h04, 5'd1, 5'd5, 16'hFFFE); tick;
    chk("beq", {a_imm, a_con()}, {32'hFFFF_FFFE, 3'b000, 1'b1, 2'b00, 4'd1});
    instr = {6'h02, 26'h123}; tick;
    chk("j", a_con(), {4'b0000, 1'b1, 1'b0, 4'd0});
    instr = r_type(5'd1, 5'd2, 5'd3, 6'h2A); tick;
    chk("slt", {a_op, a_wb}, {4'd4, 1'b1});
    instr = r_type(5'd1, 5'd2, 5'd3, 6'h22); tick;
    chk("sub", a_op, 4'd1);

    // invalid fetch slot carries no control
    valid_if = 1'b0; instr = r_type(5'd1, 5'd2, 5'd3, 6'h20); tick;
    chk("idle_slot", {a_valid, a_con()}, 11'd0);

    // 5: stall holds, flush wins over stall
    valid_if = 1'b1; instr = r_type(5'd1, 5'd2, 5'd3, 6'h20); tick;
    stall_ex = 1'b1; instr = i_type(6'h0D, 5'd0, 5'd9, 16'h00FF); #1;
    chk("stall_comb", a_stall, 1'b1);
    tick;
    chk("stall_hold", {a_valid, a_rd, a_src}, {1'b1, 5'd3, 1'b0});
    flush = 1'b1; tick;
    chk("flush_stall", {a_valid, a_con()}, 11'd0);
    flush = 1'b0; stall_ex = 1'b0;

    // 6: r0 is immutable; illegal opcode
    instr = r_type(5'd0, 5'd0, 5'd1, 6'h20);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF; tick;
    wb_en = 1'b0;
    chk("r0_same_cycle", {a_rsd, a_rtd}, 64'd0);
    tick;
    chk("r0_after", {a_rsd, a_rtd}, 64'd0);
    instr = {6'h3F, 26'h0}; tick;
    chk("illegal_op", {a_ill, a_wb}, 2'b10);
    chk("illegal_con", a_con(), 10'd0);
    instr = r_type(5'd1, 5'd2, 5'd3, 6'h21); tick;
    chk("illegal_funct", {a_ill, a_wb}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
